// File: rtl/seg_disp_pkg.sv
// Shared types and constants for the seven-segment display write arbiter.
package seg_disp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam int NUM_REQ        = 2;
  localparam int DEFAULT_DATA_W = 32;

  // Counter width for a hold of the given length; never narrower than one bit.
  function automatic int hold_cnt_w(input int cycles);
    int w;
    w = $clog2(cycles + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/seg_disp_hold_timer.sv
// Down-counter that measures how long the current owner keeps the display.
module seg_disp_hold_timer
  import seg_disp_pkg::*;
#(
  parameter int HOLD_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic done
);

  localparam int CW       = hold_cnt_w(HOLD_CYCLES);
  localparam int LOAD_VAL = (HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0;

  logic [CW-1:0] cnt;

  // Saturates at zero so a stray enable can never wrap the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CW'(LOAD_VAL);
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/seg_disp_arbiter.sv
// Round-robin arbiter giving two requesters turns at driving the display.
// Define SEG_DISP_ARB_HOLD_EN to compile in the minimum ownership hold.
module seg_disp_arbiter
  import seg_disp_pkg::*;
#(
  parameter int HOLD_CYCLES = 1_000_000,
  parameter int DATA_W      = DEFAULT_DATA_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic [DATA_W-1:0]  data0,
  input  logic [DATA_W-1:0]  data1,
  output logic [NUM_REQ-1:0] ack,
  output logic [DATA_W-1:0]  disp_data,
  output logic               disp_we,
  output logic               busy,
  output logic               owner
);

`ifdef SEG_DISP_ARB_HOLD_EN
  localparam bit HOLD_ACTIVE = (HOLD_CYCLES > 0);
`else
  localparam bit HOLD_ACTIVE = 1'b0 && (HOLD_CYCLES > 0);
`endif

  state_t state;
  logic   last_grant;
  logic   winner;
  logic   hold_done;

  // On a tie the requester that did not win last time goes next.
  assign winner = (req == 2'b11) ? ~last_grant : req[1];

`ifdef SEG_DISP_ARB_HOLD_EN
  seg_disp_hold_timer #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_hold_timer (
    .clk (clk),
    .rst (rst),
    .load(state == GRANT),
    .en  (state == HOLD),
    .done(hold_done)
  );
`else
  assign hold_done = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ack        <= '0;
      disp_we    <= 1'b0;
      disp_data  <= '0;
      owner      <= 1'b0;
      busy       <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      ack     <= '0;
      disp_we <= 1'b0;
      case (state)
        IDLE: begin
          if (|req) begin
            state      <= GRANT;
            busy       <= 1'b1;
            ack        <= winner ? 2'b10 : 2'b01;
            disp_we    <= 1'b1;
            disp_data  <= winner ? data1 : data0;
            owner      <= winner;
            last_grant <= winner;
          end
        end
        GRANT: begin
          if (HOLD_ACTIVE) begin
            state <= HOLD;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        HOLD: begin
          if (hold_done) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seg_disp_arbiter.sv
// Randomised and directed bench for seg_disp_arbiter against a cycle-budget reference model.
module tb_seg_disp_arbiter;

  localparam int HOLD_CYCLES = 4;
  localparam int DATA_W      = 32;
`ifdef SEG_DISP_ARB_HOLD_EN
  localparam int HOLD_LEN = HOLD_CYCLES;
`else
  localparam int HOLD_LEN = 0;
`endif
  localparam int PERIOD = 2 + HOLD_LEN;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        req;
  logic [DATA_W-1:0] data0, data1;
  logic [1:0]        ack;
  logic [DATA_W-1:0] disp_data;
  logic              disp_we, busy, owner;

  // Reference model: cycles left before the display is free again, plus last values shown.
  int                m_left;
  logic              m_last;
  logic              m_owner;
  logic [DATA_W-1:0] m_data;
  logic [1:0]        m_ack;
  logic              m_we;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  seg_disp_arbiter #(
    .HOLD_CYCLES(HOLD_CYCLES),
    .DATA_W     (DATA_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .data0    (data0),
    .data1    (data1),
    .ack      (ack),
    .disp_data(disp_data),
    .disp_we  (disp_we),
    .busy     (busy),
    .owner    (owner)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_left  = 0;
    m_last  = 1'b1;
    m_owner = 1'b0;
    m_data  = '0;
    m_ack   = 2'b00;
    m_we    = 1'b0;
  endtask

  // Advance one clock; the model decides who (if anyone) gets the display at this edge.
  task automatic tick();
    logic w;
    @(posedge clk);
    if (m_left == 0 && req != 2'b00) begin
      if (req == 2'b11) w = ~m_last;
      else              w = req[1];
      m_last  = w;
      m_owner = w;
      m_data  = w ? data1 : data0;
      m_ack   = w ? 2'b10 : 2'b01;
      m_we    = 1'b1;
      m_left  = 1 + HOLD_LEN;
    end else begin
      m_ack = 2'b00;
      m_we  = 1'b0;
      if (m_left > 0) m_left--;
    end
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    req   = 2'b00;
    data0 = '0;
    data1 = '0;
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    req   = 2'b00;
    data0 = 32'hFFFF_FFFF;
    data1 = 32'hFFFF_FFFF;
    model_reset();
    #2;
    n_checks++;
    if ({ack, disp_we, busy, owner, disp_data} !== {2'b00, 1'b0, 1'b0, 1'b0, 32'h0}) begin
      $display("[TB] FAIL reset: got ack=%b we=%b busy=%b owner=%b data=%h, want all zero",
               ack, disp_we, busy, owner, disp_data);
    end else n_pass++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    req   = 2'b01;
    data0 = 32'h0000_1234;
    data1 = 32'hDEAD_BEEF;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (m_ack[0]) req = 2'b00;
      n_checks++;
      if ({ack, disp_we, busy, owner, disp_data} !== {m_ack, m_we, (m_left > 0), m_owner, m_data}) begin
        $display("[TB] FAIL single cyc %0d: got ack=%b we=%b busy=%b owner=%b data=%h, want ack=%b we=%b busy=%b owner=%b data=%h",
                 cyc, ack, disp_we, busy, owner, disp_data, m_ack, m_we, (m_left > 0), m_owner, m_data);
      end else n_pass++;
    end
  endtask

  task automatic test_tie();
    do_reset();
    req   = 2'b11;
    data0 = 32'h0000_000A;
    data1 = 32'h0000_000B;
    for (int i = 0; i < 2 * PERIOD + 2; i++) begin
      tick();
      if (m_ack[0]) req[0] = 1'b0;
      if (m_ack[1]) req[1] = 1'b0;
      n_checks++;
      if ({ack, disp_we, busy, owner, disp_data} !== {m_ack, m_we, (m_left > 0), m_owner, m_data}) begin
        $display("[TB] FAIL tie cyc %0d: got ack=%b we=%b busy=%b owner=%b data=%h, want ack=%b we=%b busy=%b owner=%b data=%h",
                 cyc, ack, disp_we, busy, owner, disp_data, m_ack, m_we, (m_left > 0), m_owner, m_data);
      end else n_pass++;
    end
  endtask

  task automatic test_starvation();
    int grants0, grants1;
    grants0 = 0;
    grants1 = 0;
    do_reset();
    req   = 2'b11;
    data0 = 32'h1111_0000;
    data1 = 32'h2222_0000;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (ack[0]) grants0++;
      if (ack[1]) grants1++;
      n_checks++;
      if ({ack, disp_we, busy, owner, disp_data} !== {m_ack, m_we, (m_left > 0), m_owner, m_data}) begin
        $display("[TB] FAIL starve cyc %0d: got ack=%b we=%b busy=%b owner=%b data=%h, want ack=%b we=%b busy=%b owner=%b data=%h",
                 cyc, ack, disp_we, busy, owner, disp_data, m_ack, m_we, (m_left > 0), m_owner, m_data);
      end else n_pass++;
    end
    // Grants at ticks 1, 1+P, 1+2P, ... alternating, starting with requester 0.
    n_checks++;
    if (grants0 != (20 + PERIOD - 1) / PERIOD - (20 + PERIOD - 1) / PERIOD / 2 ||
        grants1 != (20 + PERIOD - 1) / PERIOD / 2) begin
      $display("[TB] FAIL starve_count: got grants0=%0d grants1=%0d, want %0d and %0d",
               grants0, grants1, (20 + PERIOD - 1) / PERIOD - (20 + PERIOD - 1) / PERIOD / 2,
               (20 + PERIOD - 1) / PERIOD / 2);
    end else n_pass++;
    req = 2'b00;
  endtask

  task automatic test_mid_hold_reset();
    do_reset();
    req   = 2'b01;
    data0 = $urandom;
    data1 = $urandom;
    tick();
    req = 2'b00;
    tick();
    tick();
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    n_checks++;
    if ({ack, disp_we, busy, owner, disp_data} !== {2'b00, 1'b0, 1'b0, 1'b0, 32'h0}) begin
      $display("[TB] FAIL mid_reset: got ack=%b we=%b busy=%b owner=%b data=%h, want all zero",
               ack, disp_we, busy, owner, disp_data);
    end else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i == 8) req = 2'b10;
      tick();
      if (m_ack[1]) req = 2'b00;
      n_checks++;
      if ({ack, disp_we, busy, owner, disp_data} !== {m_ack, m_we, (m_left > 0), m_owner, m_data}) begin
        $display("[TB] FAIL post_reset cyc %0d: got ack=%b we=%b busy=%b owner=%b data=%h, want ack=%b we=%b busy=%b owner=%b data=%h",
                 cyc, ack, disp_we, busy, owner, disp_data, m_ack, m_we, (m_left > 0), m_owner, m_data);
      end else n_pass++;
    end
  endtask

  task automatic test_withdrawn();
    do_reset();
    req   = 2'b01;
    data0 = 32'h0000_00C0;
    data1 = 32'h0000_00D1;
    for (int i = 0; i < 12; i++) begin
      if (i == 1) req = 2'b00;
      if (i == 2 && HOLD_LEN > 0) req = 2'b10;
      if (i == 1 && HOLD_LEN == 0) req = 2'b10;
      if (i == 3 || (i == 2 && HOLD_LEN == 0)) req = 2'b00;
      tick();
      n_checks++;
      if ({ack, disp_we, busy, owner, disp_data} !== {m_ack, m_we, (m_left > 0), m_owner, m_data}) begin
        $display("[TB] FAIL withdrawn cyc %0d: got ack=%b we=%b busy=%b owner=%b data=%h, want ack=%b we=%b busy=%b owner=%b data=%h",
                 cyc, ack, disp_we, busy, owner, disp_data, m_ack, m_we, (m_left > 0), m_owner, m_data);
      end else n_pass++;
    end
  endtask

  task automatic test_continuous();
    do_reset();
    req   = 2'b01;
    data0 = 32'h5555_AAAA;
    for (int i = 0; i < 12; i++) begin
      tick();
      n_checks++;
      if ({ack, disp_we, busy, owner, disp_data} !== {m_ack, m_we, (m_left > 0), m_owner, m_data}) begin
        $display("[TB] FAIL continuous cyc %0d: got ack=%b we=%b busy=%b owner=%b data=%h, want ack=%b we=%b busy=%b owner=%b data=%h",
                 cyc, ack, disp_we, busy, owner, disp_data, m_ack, m_we, (m_left > 0), m_owner, m_data);
      end else n_pass++;
    end
    req = 2'b00;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 300; i++) begin
      req   = 2'($urandom_range(0, 3));
      data0 = $urandom;
      data1 = $urandom;
      tick();
      n_checks++;
      if ({ack, disp_we, busy, owner, disp_data} !== {m_ack, m_we, (m_left > 0), m_owner, m_data}) begin
        $display("[TB] FAIL random cyc %0d: got ack=%b we=%b busy=%b owner=%b data=%h, want ack=%b we=%b busy=%b owner=%b data=%h",
                 cyc, ack, disp_we, busy, owner, disp_data, m_ack, m_we, (m_left > 0), m_owner, m_data);
      end else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_starvation();
    test_mid_hold_reset();
    test_withdrawn();
    test_continuous();
    test_random();
    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/seg_disp_arbiter.md
SEG_DISP_ARBITER -- requirements
Module: seg_disp_arbiter

Interface
REQ-001 The parameter list SHALL be: HOLD_CYCLES, default 1_000_000, minimum display-ownership time in clk cycles after a grant (0.1 s at 10 MHz).
REQ-002 The parameter list SHALL include: DATA_W, default 32, width of the requester and display data buses.
REQ-003 The port clk SHALL be an input, 1 bit wide: the system clock.
REQ-004 The port rst SHALL be an input, 1 bit wide: asynchronous, active-high reset.
REQ-005 The port req SHALL be an input, 2 bits wide: per-requester write request; bit0 is the CPU store path and bit1 is the debug/status source.
REQ-006 The ports data0 and data1 SHALL be inputs, DATA_W bits wide: the value each requester wants displayed.
REQ-007 The port ack SHALL be an output, 2 bits wide: a one-cycle grant/complete pulse per requester.
REQ-008 The port disp_data SHALL be an output, DATA_W bits wide: the data driven to the display peripheral's data_in.
REQ-009 The port disp_we SHALL be an output, 1 bit wide: a one-cycle write enable to the display peripheral.
REQ-010 The port busy SHALL be an output, 1 bit wide: high whenever the state is not IDLE.
REQ-011 The port owner SHALL be an output, 1 bit wide: the index of the requester whose value is currently displayed.

Function
REQ-012 The FSM SHALL have the states IDLE, GRANT and HOLD.
REQ-013 IDLE: if any req bit is sampled high at a clk edge, the FSM SHALL select the winner and go to GRANT; otherwise it SHALL stay in IDLE.
REQ-014 Arbitration SHALL be round-robin: on a single request that requester wins; on simultaneous requests, the requester not in last_grant wins.
REQ-015 GRANT SHALL last exactly one cycle, with disp_we=1, ack[winner]=1, disp_data=data[winner] (captured at the IDLE edge), and owner=winner.
REQ-016 All outputs SHALL be registered, so the latency from a req sampled in IDLE to the ack/disp_we pulse is exactly 1 cycle.
REQ-017 Handshake: a requester SHALL hold req and its data stable until ack is seen; a req deasserted before it is sampled in IDLE SHALL be ignored without an ack.
REQ-018 From GRANT, the FSM SHALL go to HOLD when the hold feature is compiled in and HOLD_CYCLES>0; otherwise it SHALL go to IDLE.
REQ-019 HOLD: the counter SHALL load HOLD_CYCLES-1 on entry and decrement each cycle; at 0 the FSM SHALL go to IDLE, giving exactly HOLD_CYCLES cycles in HOLD.
REQ-020 Requests arriving in GRANT or HOLD SHALL be held pending (not dropped) and arbitrated on the first IDLE cycle.
REQ-021 A requester holding req continuously SHALL be re-granted after each hold when the other requester is idle, and SHALL alternate with it when both request.
REQ-022 disp_data and owner SHALL retain their last granted values outside GRANT; ack and disp_we SHALL be 0 outside GRANT.
REQ-023 The hold counter width SHALL be $clog2(HOLD_CYCLES+1), with no wrap-around: decrement occurs only while in HOLD.

Reset
REQ-024 rst SHALL immediately set state=IDLE, ack=0, disp_we=0, disp_data=0, owner=0, busy=0, hold counter=0 and last_grant=1 (so requester 0 wins the first tie).
REQ-025 A reset asserted in GRANT or HOLD SHALL abort the operation with no ack issued after the release edge; requesters must re-request.

Configuration
REQ-026 The macro SEG_DISP_ARB_HOLD_EN, when defined, SHALL compile in the HOLD state and counter per REQ-018 to REQ-019.
REQ-027 When SEG_DISP_ARB_HOLD_EN is undefined, GRANT SHALL always return to IDLE, no counter SHALL exist, HOLD_CYCLES SHALL be ignored, and the back-to-back grant rate SHALL be one per 2 cycles.

Structure
REQ-028 The package seg_disp_pkg SHALL hold the state enum (IDLE, GRANT, HOLD), NUM_REQ=2 and the default DATA_W.
REQ-029 The hold counter SHALL be the sub-module seg_disp_hold_timer (inputs load and en; output done), instantiated only under SEG_DISP_ARB_HOLD_EN.
REQ-030 The arbitration and FSM logic SHALL reside in seg_disp_arbiter.

Verification (bench with HOLD_CYCLES=4 unless noted)
REQ-031 Single request: req=01, data0=0x0000_1234 -> 1 cycle later disp_we=1, ack=01, disp_data=0x0000_1234, owner=0; busy high for 5 cycles.
REQ-032 Tie after reset: req=11, data0=0xA, data1=0xB -> first grant to 0 (0xA); requester 1 is granted (0xB) on the first IDLE cycle after the 4-cycle hold.
REQ-033 Starvation: req=11 held for 20 cycles -> the ack sequence alternates 01, 10, 01, ..., with grants spaced exactly 6 cycles apart.
REQ-034 Mid-hold reset: rst pulsed at the 2nd HOLD cycle -> all outputs zero, busy=0, and no ack until a new req arrives.
REQ-035 Withdrawn request: req[1] pulsed for 1 cycle during HOLD and dropped -> no ack[1] and no disp_we for it.
REQ-036 With SEG_DISP_ARB_HOLD_EN undefined: req=01 held -> disp_we pulses every 2nd cycle and busy never exceeds 1 cycle.
